rate_divider: RTL

RATE_DIVIDER -- requirements
Module: rate_divider

---
 rtl/rate_divider_if.sv | 24 ++
 rtl/rate_divider.sv | 100 ++++++++++
 2 files changed

// File: rtl/rate_divider_if.sv
// rtl/rate_divider_if.sv - control and output bundle for the multi-channel rate divider
interface rate_divider_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic              sync_clr;
    logic              load;
    logic [2:0]        ch_sel;
    logic [CNT_W-1:0]  div_val;
    logic              mode_val;
    logic [NUM_CH-1:0] ch_tick;
    logic [NUM_CH-1:0] ch_lvl;

    modport master (
        output enable, sync_clr, load, ch_sel, div_val, mode_val,
        input  ch_tick, ch_lvl
    );

    modport slave (
        input  enable, sync_clr, load, ch_sel, div_val, mode_val,
        output ch_tick, ch_lvl
    );
endinterface

// File: rtl/rate_divider.sv
// rtl/rate_divider.sv - independent per-channel clock-enable dividers with pulse/toggle outputs
module rate_divider #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    rate_divider_if.slave  bus
);
    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  act_div  [NUM_CH];
    logic [CNT_W-1:0]  pend_div [NUM_CH];
    logic [NUM_CH-1:0] act_mode;
    logic [NUM_CH-1:0] pend_mode;
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] lvl_r;

    logic [CNT_W-1:0]  cnt_nx      [NUM_CH];
    logic [CNT_W-1:0]  act_div_nx  [NUM_CH];
    logic [CNT_W-1:0]  pend_div_nx [NUM_CH];
    logic [NUM_CH-1:0] act_mode_nx;
    logic [NUM_CH-1:0] pend_mode_nx;
    logic [NUM_CH-1:0] lvl_nx;
    logic [NUM_CH-1:0] tick_nx;
    logic [NUM_CH-1:0] out_lvl_nx;

    // Per-channel next state: pending capture, wrap detection, commit and level update
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic             hit;
            logic             wrap;
            logic             commit;
            logic [CNT_W-1:0] new_div;
            logic             new_mode;

            // ch_sel values at or above NUM_CH never match any channel index
            hit      = bus.load && (bus.ch_sel == 3'(i));
            new_div  = hit ? bus.div_val  : pend_div[i];
            new_mode = hit ? bus.mode_val : pend_mode[i];
            wrap     = bus.enable && (act_div[i] != '0) && (cnt[i] == act_div[i] - CNT_W'(1));
            // A disabled channel takes a write immediately since it will never wrap
            commit   = bus.sync_clr || wrap || ((act_div[i] == '0) && hit);

            pend_div_nx[i]  = new_div;
            pend_mode_nx[i] = new_mode;
            act_div_nx[i]   = commit ? new_div  : act_div[i];
            act_mode_nx[i]  = commit ? new_mode : act_mode[i];

            if (commit)
                cnt_nx[i] = '0;
            else if (bus.enable && (act_div[i] != '0))
                cnt_nx[i] = cnt[i] + CNT_W'(1);
            else
                cnt_nx[i] = cnt[i];

            tick_nx[i] = wrap && !bus.sync_clr;

            lvl_nx[i] = (wrap && act_mode[i]) ? ~lvl[i] : lvl[i];
            // Mode change or disabling restarts the square wave from low
            if (commit && ((new_mode != act_mode[i]) || (new_div == '0)))
                lvl_nx[i] = 1'b0;
            if (bus.sync_clr)
                lvl_nx[i] = 1'b0;

            out_lvl_nx[i] = act_mode_nx[i] ? lvl_nx[i] : tick_nx[i];
        end
    end

    // State and registered outputs; async reset restores the default configuration
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                act_div[i]  <= CNT_W'(DEF_DIV);
                pend_div[i] <= CNT_W'(DEF_DIV);
            end
            act_mode  <= '0;
            pend_mode <= '0;
            lvl       <= '0;
            tick_r    <= '0;
            lvl_r     <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= cnt_nx[i];
                act_div[i]  <= act_div_nx[i];
                pend_div[i] <= pend_div_nx[i];
            end
            act_mode  <= act_mode_nx;
            pend_mode <= pend_mode_nx;
            lvl       <= lvl_nx;
            tick_r    <= tick_nx;
            lvl_r     <= out_lvl_nx;
        end
    end

    assign bus.ch_tick = tick_r;
    assign bus.ch_lvl  = lvl_r;
endmodule
